// File: rtl/c_stream_if.sv
// Stream port bundle for c_stream: input beat, classified output beat,
// statistics clear and counters.
interface c_stream_if #(
  parameter int W       = 16,
  parameter int P_CNT_W = 16
);
  localparam int K_W = $clog2(W);

  logic               i_valid;
  logic [W-1:0]       i_x;
  logic               o_ready;
  logic               o_valid;
  logic               i_ready;
  logic               o_is_unary;
  logic               o_is_compliment;
  logic [K_W-1:0]     o_k;
  logic [W-1:0]       o_x;
  logic               i_clr;
  logic [P_CNT_W-1:0] o_accept_cnt;
  logic [P_CNT_W-1:0] o_reject_cnt;

  modport slave (
    input  i_valid, i_x, i_ready, i_clr,
    output o_ready, o_valid, o_is_unary, o_is_compliment, o_k, o_x,
           o_accept_cnt, o_reject_cnt
  );

  modport master (
    output i_valid, i_x, i_ready, i_clr,
    input  o_ready, o_valid, o_is_unary, o_is_compliment, o_k, o_x,
           o_accept_cnt, o_reject_cnt
  );
endinterface

// File: rtl/c_stream.sv
// Streaming unary/thermometer admission checker: classifies each input beat,
// buffers it in a 2-entry output FIFO and keeps saturating statistics.
module c_stream #(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
  parameter bit P_DROP_REJECT         = 1'b0,
  parameter int P_CNT_W               = 16
) (
  input  logic      clk,
  input  logic      arst_n,
  c_stream_if.slave s
);
  localparam int K_W = $clog2(W);
  localparam logic [W-1:0]       ONE_W = W'(1);
  localparam logic [P_CNT_W-1:0] ONE_C = P_CNT_W'(1);

  typedef struct packed {
    logic           u;
    logic           c;
    logic [K_W-1:0] k;
    logic [W-1:0]   x;
  } beat_t;

  typedef enum logic [1:0] {OCC_0 = 2'd0, OCC_1 = 2'd1, OCC_2 = 2'd2} occ_e;

  // True for (1<<k)-1 with k < W; all-ones is excluded because k stops at W-1.
  function automatic logic low_mask(input logic [W-1:0] v);
    return ((v & (v + ONE_W)) == '0) && (v != '1);
  endfunction

  function automatic logic [K_W-1:0] popcount(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    return K_W'(n);
  endfunction

  function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] c);
    return (c == '1) ? c : c + ONE_C;
  endfunction

  logic  norm_p0, comp_p0, xfer_p0, push_p0;
  beat_t beat_p0;

  occ_e               occ_p1, occ_nx;
  logic               rdy_p1, vld_p1, pop_p1;
  beat_t              head_p1, skid_p1, head_nx, skid_nx;
  logic [P_CNT_W-1:0] acc_p1, rej_p1, acc_nx, rej_nx;

  // ---- p0: combinational classification of the offered beat ----
  always_comb begin
    beat_p0   = '0;
    norm_p0   = low_mask(s.i_x);
    comp_p0   = P_ADMIT_COMPLIMENT_EN && low_mask(~s.i_x);
    beat_p0.u = norm_p0 | comp_p0;
    beat_p0.c = P_ADMIT_COMPLIMENT_EN && beat_p0.u && s.i_x[W-1];
    if (beat_p0.c)      beat_p0.k = popcount(~s.i_x);
    else if (beat_p0.u) beat_p0.k = popcount(s.i_x);
    beat_p0.x = s.i_x;
  end

  assign xfer_p0 = s.i_valid & rdy_p1;
  assign push_p0 = xfer_p0 & (beat_p0.u | !P_DROP_REJECT);
  assign vld_p1  = (occ_p1 != OCC_0);
  assign pop_p1  = vld_p1 & s.i_ready;

  always_comb begin
    occ_nx  = occ_p1;
    head_nx = head_p1;
    skid_nx = skid_p1;
    case (occ_p1)
      OCC_0: if (push_p0) begin
        head_nx = beat_p0;
        occ_nx  = OCC_1;
      end
      OCC_1: begin
        if (push_p0 && pop_p1) head_nx = beat_p0;
        else if (push_p0) begin
          skid_nx = beat_p0;
          occ_nx  = OCC_2;
        end else if (pop_p1) occ_nx = OCC_0;
      end
      default: if (pop_p1) begin
        head_nx = skid_p1;
        if (push_p0) skid_nx = beat_p0;
        else         occ_nx  = OCC_1;
      end
    endcase
  end

  // Clear beats a simultaneous transfer.
  always_comb begin
    acc_nx = acc_p1;
    rej_nx = rej_p1;
    if (s.i_clr) begin
      acc_nx = '0;
      rej_nx = '0;
    end else if (xfer_p0) begin
      if (beat_p0.u) acc_nx = sat_inc(acc_p1);
      else           rej_nx = sat_inc(rej_p1);
    end
  end

  // ---- p1: output/skid registers, ready flop and statistics ----
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      occ_p1  <= OCC_0;
      rdy_p1  <= 1'b0;
      head_p1 <= '0;
      skid_p1 <= '0;
      acc_p1  <= '0;
      rej_p1  <= '0;
    end else begin
      occ_p1  <= occ_nx;
      rdy_p1  <= (occ_nx != OCC_2);
      head_p1 <= head_nx;
      skid_p1 <= skid_nx;
      acc_p1  <= acc_nx;
      rej_p1  <= rej_nx;
    end
  end

  assign s.o_ready         = rdy_p1;
  assign s.o_valid         = vld_p1;
  assign s.o_is_unary      = head_p1.u;
  assign s.o_is_compliment = head_p1.c;
  assign s.o_k             = head_p1.k;
  assign s.o_x             = head_p1.x;
  assign s.o_accept_cnt    = acc_p1;
  assign s.o_reject_cnt    = rej_p1;
endmodule

// File: tb/tb_c_stream.sv
// Bench for c_stream: directed vector table, backpressure/drop/saturation/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_c_stream;
  logic clk;
  logic arst_n;
  int   checks;
  int   errors;

  c_stream_if #(.W(16), .P_CNT_W(16)) a_if ();
  c_stream_if #(.W(16), .P_CNT_W(2))  b_if ();
  c_stream_if #(.W(16), .P_CNT_W(16)) c_if ();

  c_stream #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b1), .P_DROP_REJECT(1'b0), .P_CNT_W(16))
    u_a (.clk(clk), .arst_n(arst_n), .s(a_if));
  c_stream #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b0), .P_DROP_REJECT(1'b0), .P_CNT_W(2))
    u_b (.clk(clk), .arst_n(arst_n), .s(b_if));
  c_stream #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b1), .P_DROP_REJECT(1'b1), .P_CNT_W(16))
    u_c (.clk(clk), .arst_n(arst_n), .s(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic        u;
    logic        c;
    int          k;
  } vec_t;

  localparam int CMAX_A = 65535;

  vec_t        tab[12];
  vec_t        q[$];
  vec_t        cv;
  logic [15:0] bp[3];
  logic [15:0] drained[4];
  logic [15:0] sat_x[5];
  logic [15:0] dx;
  int          exp_acc, exp_rej, sent, nd, m_acc, m_rej;
  bit          acc_now, m_rdy, in_x, out_x, dclr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference classification straight from the encoding definitions.
  function automatic vec_t classify(input logic [15:0] x, input bit compl_en);
    vec_t        r;
    logic [15:0] m;
    r.x = x; r.u = 1'b0; r.c = 1'b0; r.k = 0;
    for (int j = 0; j < 16; j++) begin
      m = 16'((32'd1 << j) - 32'd1);
      if (x == m) begin
        r.u = 1'b1; r.k = j;
      end else if (compl_en && x == ~m) begin
        r.u = 1'b1; r.c = 1'b1; r.k = j;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] gen_x();
    int          sel, k;
    logic [15:0] m;
    sel = int'($urandom_range(0, 3));
    k   = int'($urandom_range(0, 15));
    m   = 16'((32'd1 << k) - 32'd1);
    case (sel)
      0:       return m;
      1:       return ~m;
      2:       return 16'($urandom);
      default: case ($urandom_range(0, 3))
        0:       return 16'h0000;
        1:       return 16'hFFFF;
        2:       return 16'h8000;
        default: return 16'h7FFF;
      endcase
    endcase
  endfunction

  initial begin
    checks = 0; errors = 0;
    arst_n = 1'b0;
    a_if.i_valid = 0; a_if.i_x = '0; a_if.i_ready = 0; a_if.i_clr = 0;
    b_if.i_valid = 0; b_if.i_x = '0; b_if.i_ready = 0; b_if.i_clr = 0;
    c_if.i_valid = 0; c_if.i_x = '0; c_if.i_ready = 0; c_if.i_clr = 0;

    tab[0]  = '{16'h0000, 1, 0, 0};
    tab[1]  = '{16'h00FF, 1, 0, 8};
    tab[2]  = '{16'hFFFF, 1, 1, 0};
    tab[3]  = '{16'hFF00, 1, 1, 8};
    tab[4]  = '{16'h0F0F, 0, 0, 0};
    tab[5]  = '{16'h0001, 1, 0, 1};
    tab[6]  = '{16'h7FFF, 1, 0, 15};
    tab[7]  = '{16'h8000, 1, 1, 15};
    tab[8]  = '{16'hFFFE, 1, 1, 1};
    tab[9]  = '{16'h0002, 0, 0, 0};
    tab[10] = '{16'hC000, 1, 1, 14};
    tab[11] = '{16'h0010, 0, 0, 0};

    // Reset state
    repeat (2) step();
    chk("rst_valid", a_if.o_valid, 0);
    chk("rst_ready", a_if.o_ready, 0);
    chk("rst_acc", a_if.o_accept_cnt, 0);
    chk("rst_rej", a_if.o_reject_cnt, 0);
    chk("rst_x", a_if.o_x, 0);
    chk("rst_k", a_if.o_k, 0);
    @(negedge clk) arst_n = 1'b1;
    #1 chk("rdy_before_edge", a_if.o_ready, 0);
    step();
    chk("rdy_after_release", a_if.o_ready, 1);

    // Table-driven vectors at full throughput
    exp_acc = 0; exp_rej = 0;
    a_if.i_ready = 1;
    for (int i = 0; i < 12; i++) begin
      a_if.i_valid = 1; a_if.i_x = tab[i].x;
      step();
      if (tab[i].u) exp_acc++; else exp_rej++;
      chk($sformatf("tab%0d_valid", i), a_if.o_valid, 1);
      chk($sformatf("tab%0d_u", i), a_if.o_is_unary, tab[i].u);
      chk($sformatf("tab%0d_c", i), a_if.o_is_compliment, tab[i].c);
      chk($sformatf("tab%0d_k", i), a_if.o_k, 32'(tab[i].k));
      chk($sformatf("tab%0d_x", i), a_if.o_x, tab[i].x);
      chk($sformatf("tab%0d_acc", i), a_if.o_accept_cnt, exp_acc);
      chk($sformatf("tab%0d_rej", i), a_if.o_reject_cnt, exp_rej);
      chk($sformatf("tab%0d_ready", i), a_if.o_ready, 1);
    end
    a_if.i_valid = 0;
    step();
    chk("tab_drained", a_if.o_valid, 0);

    // Backpressure: only two beats fit, then in-order drain
    bp[0] = 16'h0003; bp[1] = 16'h0004; bp[2] = 16'h8000;
    a_if.i_ready = 0; sent = 0;
    for (int c = 0; c < 5; c++) begin
      a_if.i_valid = (sent < 3); a_if.i_x = bp[(sent < 3) ? sent : 0];
      acc_now = a_if.o_ready && (sent < 3);
      step();
      if (acc_now) sent++;
    end
    chk("bp_sent", sent, 2);
    chk("bp_ready_low", a_if.o_ready, 0);
    chk("bp_valid", a_if.o_valid, 1);
    chk("bp_hold_x", a_if.o_x, bp[0]);
    a_if.i_ready = 1; nd = 0;
    for (int c = 0; c < 10; c++) begin
      a_if.i_valid = (sent < 3); a_if.i_x = bp[(sent < 3) ? sent : 0];
      acc_now = a_if.o_ready && (sent < 3);
      if (a_if.o_valid) begin
        if (nd < 4) drained[nd] = a_if.o_x;
        nd++;
      end
      step();
      if (acc_now) sent++;
    end
    a_if.i_valid = 0;
    chk("bp_drain_count", nd, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("bp_order%0d", i), drained[i], bp[i]);

    // Randomized run against the reference model
    a_if.i_clr = 1;
    step();
    a_if.i_clr = 0;
    chk("clr_acc", a_if.o_accept_cnt, 0);
    chk("clr_rej", a_if.o_reject_cnt, 0);
    q.delete(); m_acc = 0; m_rej = 0; m_rdy = 1;
    for (int n = 0; n < 2000; n++) begin
      dx = gen_x(); dclr = ($urandom_range(0, 31) == 0);
      a_if.i_valid = ($urandom_range(0, 3) != 0);
      a_if.i_x     = dx;
      a_if.i_ready = ($urandom_range(0, 3) != 0);
      a_if.i_clr   = dclr;
      in_x  = a_if.i_valid && m_rdy;
      out_x = a_if.i_ready && (q.size() != 0);
      step();
      if (out_x) void'(q.pop_front());
      cv = classify(dx, 1'b1);
      if (in_x) q.push_back(cv);
      if (dclr) begin
        m_acc = 0; m_rej = 0;
      end else if (in_x) begin
        if (cv.u) m_acc = (m_acc == CMAX_A) ? m_acc : m_acc + 1;
        else      m_rej = (m_rej == CMAX_A) ? m_rej : m_rej + 1;
      end
      m_rdy = (q.size() < 2);
      chk("rnd_valid", a_if.o_valid, (q.size() != 0));
      chk("rnd_ready", a_if.o_ready, m_rdy);
      if (q.size() != 0) begin
        chk("rnd_x", a_if.o_x, q[0].x);
        chk("rnd_u", a_if.o_is_unary, q[0].u);
        chk("rnd_c", a_if.o_is_compliment, q[0].c);
        chk("rnd_k", a_if.o_k, 32'(q[0].k));
      end
      chk("rnd_acc", a_if.o_accept_cnt, m_acc);
      chk("rnd_rej", a_if.o_reject_cnt, m_rej);
    end
    a_if.i_valid = 0; a_if.i_clr = 0; a_if.i_ready = 1;
    repeat (3) step();

    // Complement disabled: all-ones and high-mask rejected
    b_if.i_ready = 1;
    b_if.i_valid = 1; b_if.i_x = 16'hFFFF;
    step();
    chk("nc_ffff_valid", b_if.o_valid, 1);
    chk("nc_ffff_u", b_if.o_is_unary, 0);
    chk("nc_ffff_c", b_if.o_is_compliment, 0);
    b_if.i_x = 16'h8000;
    step();
    chk("nc_8000_u", b_if.o_is_unary, 0);
    chk("nc_8000_x", b_if.o_x, 16'h8000);
    chk("nc_8000_k", b_if.o_k, 0);
    b_if.i_valid = 0;
    step();
    chk("nc_rej", b_if.o_reject_cnt, 2);
    chk("nc_acc", b_if.o_accept_cnt, 0);

    // 2-bit counters saturate, clear wins over a coincident transfer
    sat_x[0] = 16'h0001; sat_x[1] = 16'h0003; sat_x[2] = 16'h0000;
    sat_x[3] = 16'h0007; sat_x[4] = 16'h000F;
    for (int i = 0; i < 5; i++) begin
      b_if.i_valid = 1; b_if.i_x = sat_x[i];
      step();
      chk($sformatf("sat_acc%0d", i), b_if.o_accept_cnt, (i + 1 > 3) ? 3 : i + 1);
    end
    b_if.i_x = 16'h001F; b_if.i_clr = 1;
    step();
    b_if.i_valid = 0; b_if.i_clr = 0;
    chk("sat_clr_acc", b_if.o_accept_cnt, 0);
    chk("sat_clr_rej", b_if.o_reject_cnt, 0);
    step();
    chk("sat_clr_hold", b_if.o_accept_cnt, 0);

    // Drop mode: rejected beat counted but never presented
    c_if.i_ready = 1;
    c_if.i_valid = 1; c_if.i_x = 16'h0003;
    step();
    chk("drop_b0_valid", c_if.o_valid, 1);
    chk("drop_b0_x", c_if.o_x, 16'h0003);
    chk("drop_b0_k", c_if.o_k, 2);
    c_if.i_x = 16'h0005;
    step();
    chk("drop_b1_valid", c_if.o_valid, 0);
    chk("drop_b1_ready", c_if.o_ready, 1);
    c_if.i_x = 16'h0007;
    step();
    chk("drop_b2_valid", c_if.o_valid, 1);
    chk("drop_b2_x", c_if.o_x, 16'h0007);
    chk("drop_b2_k", c_if.o_k, 3);
    c_if.i_valid = 0;
    step();
    chk("drop_end_valid", c_if.o_valid, 0);
    chk("drop_rej", c_if.o_reject_cnt, 1);
    chk("drop_acc", c_if.o_accept_cnt, 2);

    // Asynchronous reset with the FIFO full
    a_if.i_ready = 0; a_if.i_clr = 1;
    step();
    a_if.i_clr = 0; a_if.i_valid = 1; a_if.i_x = 16'h0003;
    repeat (3) step();
    chk("full_ready", a_if.o_ready, 0);
    chk("full_valid", a_if.o_valid, 1);
    chk("full_acc", a_if.o_accept_cnt, 2);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_valid", a_if.o_valid, 0);
    chk("arst_ready", a_if.o_ready, 0);
    chk("arst_acc", a_if.o_accept_cnt, 0);
    chk("arst_x", a_if.o_x, 0);
    chk("arst_b_acc", b_if.o_accept_cnt, 0);
    a_if.i_valid = 0;
    @(negedge clk) arst_n = 1'b1;
    step();
    chk("arst_release_ready", a_if.o_ready, 1);
    chk("arst_release_valid", a_if.o_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
